// File: rtl/bounce_sequencer.sv
// bounce_sequencer: keeps NOBJ bouncing squares and advances each of them once
// per frame. A sweep starts on frame_start and visits every object twice
// (x axis, then y axis) through one shared edge/step unit, so a full sweep
// takes 2*NOBJ pixel clocks.
// Optional feature: define BOUNCE_PAUSE_EN to add a 'pause' input. When it is
// high, a frame_start skips the sweep but still pulses done.
module bounce_sequencer #(
   parameter int  CORDW = 10,
   parameter int  NOBJ  = 4,
   parameter int  H_RES = 640,
   parameter int  V_RES = 480,
   localparam int IDXW  = $clog2(NOBJ)
) (
   input  logic             clk_pix,
   input  logic             rst_n,
   input  logic             frame_start,
`ifdef BOUNCE_PAUSE_EN
   input  logic             pause,
`endif
   input  logic             cfg_we,
   input  logic [IDXW-1:0]  cfg_idx,
   input  logic [CORDW-1:0] cfg_x,
   input  logic [CORDW-1:0] cfg_y,
   input  logic [CORDW-1:0] cfg_size,
   input  logic [3:0]       cfg_spd,
   input  logic [IDXW-1:0]  rd_idx,
   output logic [CORDW-1:0] rd_x,
   output logic [CORDW-1:0] rd_y,
   output logic [CORDW-1:0] rd_size,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   // Two guard bits so that size+spd and limit-(size+spd) never wrap.
   localparam int             AW       = CORDW + 2;
   localparam logic [AW-1:0]  H_LIM    = AW'(H_RES);
   localparam logic [AW-1:0]  V_LIM    = AW'(V_RES);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NOBJ - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      UPD_X = 2'd1,
      UPD_Y = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IDXW-1:0] idx;
   logic [IDXW-1:0] idx_nxt;
   logic            done_nxt;

   // Per-object registers; dir bit 0 means moving right (x) or down (y).
   logic [CORDW-1:0] x_r    [NOBJ];
   logic [CORDW-1:0] y_r    [NOBJ];
   logic [CORDW-1:0] size_r [NOBJ];
   logic [3:0]       spd_r  [NOBJ];
   logic [NOBJ-1:0]  dx_r;
   logic [NOBJ-1:0]  dy_r;

   // Shared edge/step unit signals.
   logic [AW-1:0]    ax_pos;
   logic [AW-1:0]    ax_size;
   logic [AW-1:0]    ax_spd;
   logic [AW-1:0]    ax_lim;
   logic [AW-1:0]    ax_sum;
   logic [AW-1:0]    ax_thr;
   logic             ax_dir;
   logic             ax_dir_nxt;
   logic             ax_hold;
   logic [CORDW-1:0] ax_pos_nxt;

   logic pause_i;
   logic sweep_go;
   logic skip_go;
   logic cfg_ok;
   logic last_step;

`ifdef BOUNCE_PAUSE_EN
   assign pause_i = pause;
`else
   assign pause_i = 1'b0;
`endif

   // A frame_start in IDLE either launches a sweep or, when paused, is
   // acknowledged with a done pulse only. Any frame_start seen while a sweep
   // is running is an overrun.
   assign sweep_go  = (state == IDLE) && frame_start && !pause_i;
   assign skip_go   = (state == IDLE) && frame_start &&  pause_i;
   assign last_step = (state == UPD_Y) && (idx == LAST_IDX);

   // Configuration writes must not race a sweep, so they are taken only when
   // the sequencer is idle and no sweep is starting in the same cycle.
   assign cfg_ok = cfg_we && (state == IDLE) && !frame_start;

   assign busy = (state != IDLE);

   // Zero-latency read port straight from the object registers.
   assign rd_x    = x_r[rd_idx];
   assign rd_y    = y_r[rd_idx];
   assign rd_size = size_r[rd_idx];

   // Select the operands of the current object and axis for the step unit.
   always_comb begin
      ax_size = AW'(size_r[idx]);
      ax_spd  = AW'(spd_r[idx]);
      ax_pos  = AW'(x_r[idx]);
      ax_dir  = dx_r[idx];
      ax_lim  = H_LIM;
      if (state == UPD_Y) begin
         ax_pos = AW'(y_r[idx]);
         ax_dir = dy_r[idx];
         ax_lim = V_LIM;
      end
   end

   // Bounce rule: reflect off the far edge, then the near edge, otherwise
   // keep moving. Objects that cannot fit or have no speed stay put.
   always_comb begin
      ax_sum     = ax_size + ax_spd;
      ax_thr     = ax_lim - ax_sum;
      ax_hold    = (ax_spd == '0) || (ax_sum >= ax_lim);
      ax_dir_nxt = ax_dir;
      ax_pos_nxt = CORDW'(ax_pos);
      if (ax_pos >= ax_thr) begin
         ax_dir_nxt = 1'b1;
         ax_pos_nxt = CORDW'(ax_pos - ax_spd);
      end else if (ax_pos < ax_spd) begin
         ax_dir_nxt = 1'b0;
         ax_pos_nxt = CORDW'(ax_pos + ax_spd);
      end else if (ax_dir) begin
         ax_pos_nxt = CORDW'(ax_pos - ax_spd);
      end else begin
         ax_pos_nxt = CORDW'(ax_pos + ax_spd);
      end
   end

   // Next-state logic of the sweep: x then y for each object in turn.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      done_nxt  = last_step || skip_go;
      case (state)
         IDLE: begin
            if (sweep_go) begin
               state_nxt = UPD_X;
               idx_nxt   = '0;
            end
         end
         UPD_X: begin
            state_nxt = UPD_Y;
         end
         UPD_Y: begin
            if (idx == LAST_IDX) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               state_nxt = UPD_X;
               idx_nxt   = idx + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // Sequencer registers: state, object index, done pulse, sticky overrun.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         idx     <= '0;
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         done  <= done_nxt;
         if (frame_start && (state != IDLE)) begin
            overrun <= 1'b1;
         end
      end
   end

   // Object registers: loaded by configuration writes, advanced one axis per
   // cycle by the step unit during a sweep.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NOBJ; i++) begin
            x_r[i]    <= '0;
            y_r[i]    <= '0;
            size_r[i] <= '0;
            spd_r[i]  <= '0;
         end
         dx_r <= '0;
         dy_r <= '0;
      end else begin
         if (cfg_ok) begin
            x_r[cfg_idx]    <= cfg_x;
            y_r[cfg_idx]    <= cfg_y;
            size_r[cfg_idx] <= cfg_size;
            spd_r[cfg_idx]  <= cfg_spd;
            dx_r[cfg_idx]   <= 1'b0;
            dy_r[cfg_idx]   <= 1'b0;
         end
         if ((state == UPD_X) && !ax_hold) begin
            x_r[idx]  <= ax_pos_nxt;
            dx_r[idx] <= ax_dir_nxt;
         end
         if ((state == UPD_Y) && !ax_hold) begin
            y_r[idx]  <= ax_pos_nxt;
            dy_r[idx] <= ax_dir_nxt;
         end
      end
   end

endmodule

// File: tb/tb_bounce_sequencer.sv
// tb_bounce_sequencer: directed table, hand-written corner sequences and
// randomized configurations for bounce_sequencer, checked against a simple
// per-frame model of the bounce rules.
module tb_bounce_sequencer;

   localparam int CORDW = 10;
   localparam int NOBJ  = 4;
   localparam int IDXW  = 2;
   localparam int H_RES = 640;
   localparam int V_RES = 480;
   localparam int MASK  = (1 << CORDW) - 1;

   logic             clk_pix;
   logic             rst_n;
   logic             frame_start;
`ifdef BOUNCE_PAUSE_EN
   logic             pause;
`endif
   logic             cfg_we;
   logic [IDXW-1:0]  cfg_idx;
   logic [CORDW-1:0] cfg_x;
   logic [CORDW-1:0] cfg_y;
   logic [CORDW-1:0] cfg_size;
   logic [3:0]       cfg_spd;
   logic [IDXW-1:0]  rd_idx;
   logic [CORDW-1:0] rd_x;
   logic [CORDW-1:0] rd_y;
   logic [CORDW-1:0] rd_size;
   logic             busy;
   logic             done;
   logic             overrun;

   int n_cmp;
   int n_bad;

   // Reference model state.
   int m_x    [NOBJ];
   int m_y    [NOBJ];
   int m_size [NOBJ];
   int m_spd  [NOBJ];
   int m_dx   [NOBJ];
   int m_dy   [NOBJ];

   typedef struct {
      int do_cfg;
      int obj;
      int x;
      int y;
      int size;
      int spd;
      int frames;
      int exp_x;
      int exp_y;
   } vec_t;

   vec_t vecs [10];

   bounce_sequencer #(
      .CORDW (CORDW),
      .NOBJ  (NOBJ),
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) dut (
      .clk_pix     (clk_pix),
      .rst_n       (rst_n),
      .frame_start (frame_start),
`ifdef BOUNCE_PAUSE_EN
      .pause       (pause),
`endif
      .cfg_we      (cfg_we),
      .cfg_idx     (cfg_idx),
      .cfg_x       (cfg_x),
      .cfg_y       (cfg_y),
      .cfg_size    (cfg_size),
      .cfg_spd     (cfg_spd),
      .rd_idx      (rd_idx),
      .rd_x        (rd_x),
      .rd_y        (rd_y),
      .rd_size     (rd_size),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun)
   );

   initial clk_pix = 1'b0;
   always #5 clk_pix = ~clk_pix;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk_pix);
      #1;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One axis of the bounce rule, in plain integer arithmetic.
   function automatic void step_axis(input int pos, input int dir, input int size,
                                     input int spd, input int lim,
                                     output int pos_o, output int dir_o);
      pos_o = pos;
      dir_o = dir;
      if (spd == 0 || size + spd >= lim) return;
      if (pos >= lim - (size + spd)) begin
         dir_o = 1;
         pos_o = pos - spd;
      end else if (pos < spd) begin
         dir_o = 0;
         pos_o = pos + spd;
      end else begin
         pos_o = (dir != 0) ? pos - spd : pos + spd;
      end
      pos_o = pos_o & MASK;
   endfunction

   task automatic model_reset();
      for (int o = 0; o < NOBJ; o++) begin
         m_x[o] = 0; m_y[o] = 0; m_size[o] = 0;
         m_spd[o] = 0; m_dx[o] = 0; m_dy[o] = 0;
      end
   endtask

   task automatic model_frame();
      int p, d;
      for (int o = 0; o < NOBJ; o++) begin
         step_axis(m_x[o], m_dx[o], m_size[o], m_spd[o], H_RES, p, d);
         m_x[o] = p; m_dx[o] = d;
         step_axis(m_y[o], m_dy[o], m_size[o], m_spd[o], V_RES, p, d);
         m_y[o] = p; m_dy[o] = d;
      end
   endtask

   // Configuration write of one object while idle; the model follows.
   task automatic applyStimulus(input int o, input int x, input int y,
                                input int size, input int spd);
      cfg_idx  = o[IDXW-1:0];
      cfg_x    = x[CORDW-1:0];
      cfg_y    = y[CORDW-1:0];
      cfg_size = size[CORDW-1:0];
      cfg_spd  = spd[3:0];
      cfg_we   = 1'b1;
      tick();
      cfg_we   = 1'b0;
      m_x[o] = x & MASK; m_y[o] = y & MASK; m_size[o] = size & MASK;
      m_spd[o] = spd & 15; m_dx[o] = 0; m_dy[o] = 0;
   endtask

   task automatic checkAll();
      for (int o = 0; o < NOBJ; o++) begin
         rd_idx = o[IDXW-1:0];
         #1;
         checkOutput($sformatf("obj%0d_x", o), int'(rd_x), m_x[o]);
         checkOutput($sformatf("obj%0d_y", o), int'(rd_y), m_y[o]);
         checkOutput($sformatf("obj%0d_size", o), int'(rd_size), m_size[o]);
      end
   endtask

   // One frame: pulse frame_start, watch busy/done for a bounded window.
   // Optional disturbances: a second frame_start, a cfg write mid-sweep,
   // a cfg write coincident with frame_start, pause.
   task automatic run_frame(input int extra_fs_cyc, input int cfg_cyc,
                            input bit cfg_with_fs, input bit use_pause);
      int first_busy = 0;
      int busy_cnt   = 0;
      int done_cyc   = 0;
      int done_cnt   = 0;
      if (cfg_with_fs) begin
         cfg_idx = 2'd3; cfg_x = 10'd777; cfg_y = 10'd333;
         cfg_size = 10'd5; cfg_spd = 4'd9; cfg_we = 1'b1;
      end
`ifdef BOUNCE_PAUSE_EN
      pause = use_pause;
`endif
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      cfg_we      = 1'b0;
`ifdef BOUNCE_PAUSE_EN
      pause = 1'b0;
`endif
      for (int c = 1; c <= 14; c++) begin
         if (busy) begin
            busy_cnt++;
            if (first_busy == 0) first_busy = c;
         end
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (c == extra_fs_cyc) frame_start = 1'b1;
         if (c == cfg_cyc) begin
            cfg_idx = 2'd0; cfg_x = 10'd999; cfg_y = 10'd888;
            cfg_size = 10'd1; cfg_spd = 4'd7; cfg_we = 1'b1;
         end
         tick();
         frame_start = 1'b0;
         cfg_we      = 1'b0;
      end
      checkOutput("busy_first_cycle", first_busy, use_pause ? 0 : 1);
      checkOutput("busy_cycles", busy_cnt, use_pause ? 0 : 2 * NOBJ);
      checkOutput("done_cycle", done_cyc, use_pause ? 1 : 2 * NOBJ + 1);
      checkOutput("done_pulses", done_cnt, 1);
      if (!use_pause) model_frame();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      frame_start = 1'b0;
`ifdef BOUNCE_PAUSE_EN
      pause = 1'b0;
`endif
      cfg_we = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0;
      cfg_size = '0; cfg_spd = '0; rd_idx = '0;
      model_reset();

      // Directed vectors: {cfg?, obj, x, y, size, spd, frames, exp x, exp y}.
      vecs[0] = '{1, 0, 100,  50, 100, 2, 1, 102,  52};
      vecs[1] = '{1, 1, 489,  10, 150, 3, 1, 486,  13};
      vecs[2] = '{0, 1,   0,   0,   0, 0, 1, 483,  16};
      vecs[3] = '{1, 2,  10,  20, 630, 3, 3,   1,  20};
      vecs[4] = '{0, 2,   0,   0,   0, 0, 1,   4,  20};
      vecs[5] = '{0, 2,   0,   0,   0, 0, 1,   7,  20};
      vecs[6] = '{1, 3, 300, 100, 639, 1, 2, 300, 100};
      vecs[7] = '{1, 3, 300, 100, 638, 1, 1, 299, 100};
      vecs[8] = '{1, 0,   5,   7,  10, 0, 2,   5,   7};
      vecs[9] = '{1, 1,   1,   0,  10, 5, 1,   6,   5};

      // Reset state.
      repeat (2) @(posedge clk_pix);
      #1;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_overrun", int'(overrun), 0);
      checkAll();
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 10; v++) begin
         if (vecs[v].do_cfg != 0)
            applyStimulus(vecs[v].obj, vecs[v].x, vecs[v].y, vecs[v].size, vecs[v].spd);
         for (int f = 0; f < vecs[v].frames; f++) run_frame(0, 0, 1'b0, 1'b0);
         rd_idx = vecs[v].obj[IDXW-1:0];
         #1;
         checkOutput($sformatf("vec%0d_x", v), int'(rd_x), vecs[v].exp_x);
         checkOutput($sformatf("vec%0d_y", v), int'(rd_y), vecs[v].exp_y);
         checkAll();
      end

      // Second frame_start three cycles into a sweep.
      checkOutput("overrun_before", int'(overrun), 0);
      run_frame(3, 0, 1'b0, 1'b0);
      checkOutput("overrun_set", int'(overrun), 1);
      checkAll();

      // Config writes during a sweep and coincident with frame_start are dropped.
      run_frame(0, 4, 1'b0, 1'b0);
      checkAll();
      run_frame(0, 0, 1'b1, 1'b0);
      checkAll();
      checkOutput("overrun_sticky", int'(overrun), 1);

`ifdef BOUNCE_PAUSE_EN
      // Paused frame: no sweep, done next cycle, nothing moves.
      applyStimulus(0, 200, 200, 20, 4);
      run_frame(0, 0, 1'b0, 1'b1);
      checkAll();
      run_frame(0, 0, 1'b0, 1'b0);
      checkAll();
`endif

      // Randomized configurations and frame counts.
      for (int r = 0; r < 30; r++) begin
         applyStimulus($urandom_range(NOBJ - 1), $urandom_range(MASK),
                       $urandom_range(MASK), $urandom_range(700),
                       $urandom_range(15));
         for (int f = 0; f < int'($urandom_range(3, 1)); f++) run_frame(0, 0, 1'b0, 1'b0);
         checkAll();
      end

      // Reset in the middle of a sweep.
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
      tick();
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", int'(busy), 0);
      checkOutput("midreset_done", int'(done), 0);
      checkOutput("midreset_overrun", int'(overrun), 0);
      model_reset();
      checkAll();
      @(posedge clk_pix);
      #1;
      rst_n = 1'b1;
      tick();
      applyStimulus(0, 100, 50, 100, 2);
      run_frame(0, 0, 1'b0, 1'b0);
      rd_idx = '0;
      #1;
      checkOutput("after_reset_x", int'(rd_x), 102);
      checkOutput("after_reset_y", int'(rd_y), 52);
      checkAll();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
